// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the fetch path: default PC width, instruction
// word type, major opcode constants and the fetch FSM state encoding.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef logic [31:0] instr_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam instr_t NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_buf.sv
// Small synchronous FIFO of {pc, instr} pairs feeding decode. The head entry
// is read straight from the storage registers, so the outputs never depend
// combinationally on the write side. Flush empties the FIFO in one cycle.
module ifetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PCW   = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           push,
  input  logic [PCW-1:0] push_pc,
  input  instr_t         push_instr,
  input  logic           pop,
  output logic           head_valid,
  output logic [PCW-1:0] head_pc,
  output instr_t         head_instr,
  output logic [CW-1:0]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PCW-1:0] mem_pc    [DEPTH];
  instr_t         mem_instr [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_valid = (count != '0);
  assign head_pc    = mem_pc[rd_ptr];
  assign head_instr = mem_instr[rd_ptr];

  // Storage, pointers and occupancy; flush discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_pc[wr_ptr]    <= push_pc;
        mem_instr[wr_ptr] <= push_instr;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned requests to instruction memory,
// buffers returned words with their PC and hands them to decode. A redirect
// from the controller flushes the buffer and marks every in-flight response
// for discard. Optional performance counters under `IFETCH_PERF_EN.
//
// state  | meaning
// S_BOOT | first cycle after reset, no requests issued, redirects ignored
// S_RUN  | buffered + outstanding < BUF_DEPTH, request valid
// S_FULL | buffered + outstanding == BUF_DEPTH, request withheld
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN      = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  instr_t          imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output instr_t          instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   out_next;
  logic [CW-1:0]   buf_next;
  logic [CW:0]     sum_next;
  logic [XLEN-1:0] target_al;
  logic            accept;
  logic            redirect;
  logic            drop;
  logic            keep;
  logic            pop_raw;
  logic            push_en;
  logic            pop_en;

  assign imem_req_valid = (state == S_RUN);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign redirect       = pc_src && (state != S_BOOT);
  assign target_al      = {pc_target[XLEN-1:2], 2'b00};
  assign drop           = imem_rsp_valid && (discard != '0);
  assign keep           = imem_rsp_valid && !drop;
  assign pop_raw        = instr_valid && instr_ready;
  assign push_en        = keep && !redirect;
  assign pop_en         = pop_raw && !redirect;

  ifetch_buf #(
    .DEPTH (BUF_DEPTH),
    .PCW   (XLEN),
    .CW    (CW)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (push_en),
    .push_pc    (rsp_pc),
    .push_instr (imem_rsp_data),
    .pop        (pop_en),
    .head_valid (instr_valid),
    .head_pc    (instr_pc),
    .head_instr (instr),
    .count      (buf_count)
  );

  // Next-cycle occupancy, used to pick S_RUN/S_FULL one step ahead so the
  // registered state always matches the current buffered + outstanding sum.
  always_comb begin
    out_next = outstanding;
    case ({accept, imem_rsp_valid})
      2'b10:   out_next = outstanding + CW'(1);
      2'b01:   out_next = outstanding - CW'(1);
      default: out_next = outstanding;
    endcase
    buf_next = buf_count;
    if (redirect) begin
      buf_next = '0;
    end else begin
      case ({push_en, pop_en})
        2'b10:   buf_next = buf_count + CW'(1);
        2'b01:   buf_next = buf_count - CW'(1);
        default: buf_next = buf_count;
      endcase
    end
    sum_next = {1'b0, buf_next} + {1'b0, out_next};
  end

  // Fetch FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      case (state)
        S_BOOT:  state <= S_RUN;
        default: state <= (sum_next >= (CW + 1)'(BUF_DEPTH)) ? S_FULL : S_RUN;
      endcase
    end
  end

  // Request PC and the PC tag of the next response that will be kept.
  // After a redirect every in-flight word is discarded, so the next kept
  // response belongs to the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target_al;
      rsp_pc   <= target_al;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (push_en) begin
        rsp_pc <= rsp_pc + XLEN'(4);
      end
    end
  end

  // In-flight and discard accounting. On redirect everything still in
  // flight after this cycle, including a same-cycle accept, is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        discard <= out_next;
      end else if (drop) begin
        discard <= discard - CW'(1);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  // Delivered and thrown-away word counters, wrapping silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop_raw);
      perf_flushed <= perf_flushed + 32'(drop) +
                      (redirect ? (32'(buf_count) - 32'(pop_raw) + 32'(keep)) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with variable latency, and a
// scoreboard that tracks the program-order PC stream decode must see, the
// request address stream, and the delivered/flushed word totals.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        pc_src;
  logic [31:0] pc_target;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_src         (pc_src),
    .pc_target      (pc_target)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;
  bit    lat_rand = 0;
  int    rsp_epoch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: returns words in order, at most one per cycle, no backpressure.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq[0].addr);
        rsp_epoch      = mq[0].epoch;
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Scoreboard / reference model state, owned by the monitor.
  logic [31:0] exp_pc, exp_req, prev_addr, first_val_pc;
  int          epoch, mbuf, delivered, flushed, acc_cnt;
  int          first_acc, first_val, last_due, l, due;
  bit          prev_stall;
  mreq_t       ent;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pc = '0; exp_req = '0; epoch = 0; mbuf = 0; delivered = 0; flushed = 0;
        acc_cnt = 0; prev_stall = 0; prev_addr = '0; first_acc = -1; first_val = -1;
        first_val_pc = '1; last_due = 0;
      end else begin
        if (prev_stall) begin
          chk("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
          chk("req_hold_addr", imem_req_addr, prev_addr);
        end
        prev_stall = imem_req_valid && !imem_req_ready && !pc_src;
        prev_addr  = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, exp_req);
          l   = lat_rand ? int'($urandom_range(1, 4)) : lat;
          due = cyc + l;
          if (due <= last_due) due = last_due + 1;
          last_due  = due;
          ent.addr  = imem_req_addr;
          ent.due   = due;
          ent.epoch = epoch;
          mq.push_back(ent);
          exp_req = exp_req + 32'd4;
          acc_cnt++;
          if (first_acc < 0) first_acc = cyc;
        end
        if (imem_rsp_valid) begin
          if (rsp_epoch == epoch) mbuf++;
          else flushed++;
        end
        if (instr_valid && instr_ready) begin
          chk("instr_pc", instr_pc, exp_pc);
          chk("instr_word", instr, mem_word(exp_pc));
          if (first_val < 0) begin
            first_val    = cyc;
            first_val_pc = instr_pc;
          end
          exp_pc = exp_pc + 32'd4;
          mbuf--;
          delivered++;
        end
        if (pc_src) begin
          exp_pc  = pc_target & ~32'd3;
          exp_req = pc_target & ~32'd3;
          flushed = flushed + mbuf;
          mbuf    = 0;
          epoch++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

`ifdef IFETCH_PERF_EN
  task automatic chk_perf(input string tag);
    chk({tag, "_perf_fetched"}, perf_fetched, delivered);
    chk({tag, "_perf_flushed"}, perf_flushed, flushed);
  endtask
`endif

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  bit hit;
  int a0, d0;

  initial begin
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    pc_src         = 1'b0;
    pc_target      = '0;
    #1 rst_n = 1'b0;
    repeat (3) step();

    // Reset values
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef IFETCH_PERF_EN
    chk_perf("rst");
`endif

    // 1: sequential fetch, 1-cycle memory, decode always ready
    rst_n = 1'b1;
    repeat (20) step();
    chk("p1_first_latency", 32'(first_val - first_acc), 32'd2);
    chk("p1_first_pc", first_val_pc, 32'h0);

    // 2: decode stalled for 10 cycles from reset
    instr_ready = 1'b0;
    do_reset();
    repeat (10) step();
    chk("p2_accepts", 32'(acc_cnt), 32'd2);
    chk("p2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    instr_ready = 1'b1;
    repeat (10) step();
    chk("p2_delivered", {31'b0, delivered >= 2}, 32'd1);

    // 3: redirect to 0x100 with two requests in flight
    lat = 4;
    do_reset();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (delivered >= 2 && mq.size() == 2) hit = 1;
      else step();
    end
    chk("p3_setup", {31'b0, hit}, 32'd1);
    pc_src = 1'b1;
    pc_target = 32'h100;
    step();
    pc_src = 1'b0;
    d0 = delivered;
    repeat (20) step();
    chk("p3_progress", {31'b0, delivered > d0 + 1}, 32'd1);
`ifdef IFETCH_PERF_EN
    chk_perf("p3");
`endif

    // 4: redirect coinciding with a request accept and a response
    lat = 1;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      instr_ready = ($urandom_range(0, 1) == 1);
      if (imem_req_valid && imem_rsp_valid) hit = 1;
      else step();
    end
    chk("p4_setup", {31'b0, hit}, 32'd1);
    pc_src = 1'b1;
    pc_target = 32'h203;
    step();
    pc_src = 1'b0;
    chk("p4_target_addr", imem_req_addr, 32'h200);
    instr_ready = 1'b1;
    repeat (10) step();

    // 5: memory refuses requests for 5 cycles
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (imem_req_valid) hit = 1;
      else step();
    end
    chk("p5_setup", {31'b0, hit}, 32'd1);
    imem_req_ready = 1'b0;
    a0 = acc_cnt;
    repeat (5) step();
    chk("p5_stall_accepts", 32'(acc_cnt - a0), 32'd0);
    imem_req_ready = 1'b1;
    step();
    chk("p5_release_accepts", 32'(acc_cnt - a0), 32'd1);

    // 6: random traffic and redirects
    lat_rand = 1;
    d0 = delivered;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      pc_src         = ($urandom_range(0, 15) == 0);
      pc_target      = $urandom;
      step();
    end
    pc_src = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    repeat (10) step();
    chk("p6_progress", {31'b0, delivered - d0 > 50}, 32'd1);
`ifdef IFETCH_PERF_EN
    chk_perf("end");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
